// File: rtl/port_pkg.sv
// Shared definitions for the CPU port FIFOs: status word layout and packing helper.
package port_pkg;

  localparam int STATUS_FULL_BIT  = 15;
  localparam int STATUS_EMPTY_BIT = 14;
  localparam int STATUS_OVF_BIT   = 13;
  localparam int STATUS_CNT_W     = 8;

  // Status word as the CPU sees it through port_d_in
  typedef struct packed {
    logic                    full;      // [15]
    logic                    empty;     // [14]
    logic                    overflow;  // [13]
    logic [4:0]              rsvd;      // [12:8], always zero
    logic [STATUS_CNT_W-1:0] count;     // [7:0]
  } port_status_t;

  // Assemble a status word; reserved bits forced to zero
  function automatic port_status_t pack_status(input logic                    full,
                                               input logic                    empty,
                                               input logic                    overflow,
                                               input logic [STATUS_CNT_W-1:0] count);
    port_status_t s;
    s.full     = full;
    s.empty    = empty;
    s.overflow = overflow;
    s.rsvd     = 5'd0;
    s.count    = count;
    return s;
  endfunction

endpackage

// File: rtl/port_fifo_core.sv
// Generic first-word-fall-through FIFO core: storage, pointers, occupancy count.
// Push/pop are assumed already qualified by the caller (no internal overflow guard),
// which keeps the core reusable for both transmit and receive port FIFOs.
module port_fifo_core
  import port_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             empty_s;
  logic             full_s;

  assign empty_s = (count_r == CNT_W'(0));
  assign full_s  = (count_r == CNT_W'(DEPTH));

  // Storage write; contents are not reset, only written on a qualified push
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head word; forced to zero while empty so unreset storage never leaks out
  always_comb begin
    rdata = {WIDTH{1'b0}};
    if (empty_s) begin
      rdata = {WIDTH{1'b0}};
    end else begin
      rdata = mem_r[rd_ptr_r];
    end
  end

  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/port_tx_fifo.sv
// CPU output-port transmit FIFO: captures port writes, drains them to a peripheral
// over valid/ready, and reports full/empty/overflow/count back to the CPU.
module port_tx_fifo
  import port_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_strobe,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_strobe,
  output logic [15:0]      status,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] count_s;
  logic [WIDTH-1:0] head_s;
  logic             overflow_r;
  port_status_t     status_s;

  // A pop frees a slot in the same cycle, so a write to a full FIFO is still accepted then
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (rst_n) begin
      pop_s  = !empty_s & m_ready;
      push_s = wr_strobe & (!full_s | pop_s);
      drop_s = wr_strobe & full_s & !pop_s;
    end else begin
      pop_s  = 1'b0;
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  port_fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wr_data),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Sticky overflow: a drop sets it, a CPU status read clears it; set wins on a tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (rd_strobe) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Status word packed from registered state only
  always_comb begin
    status_s = pack_status(full_s, empty_s, overflow_r, STATUS_CNT_W'(count_s));
  end

  assign status  = status_s;
  assign m_valid = !empty_s;
  assign m_data  = head_s;

endmodule

// File: tb/tb_port_tx_fifo.sv
// Self-checking bench for port_tx_fifo: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_port_tx_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             wr_strobe;
  logic [WIDTH-1:0] wr_data;
  logic             rd_strobe;
  logic [15:0]      status;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  int n_total;
  int n_pass;

  port_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_strobe (wr_strobe),
    .wr_data   (wr_data),
    .rd_strobe (rd_strobe),
    .status    (status),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] wd;
    logic        rd;
    logic        rdy;
    logic [15:0] exp_status;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_strobe = 1'b0;
    wr_data   = 16'hxxxx;
    rd_strobe = 1'b0;
    m_ready   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_outs(input string name, input logic [15:0] st, input logic v, input logic [15:0] d);
    chk({name, "_status"}, {16'd0, status}, {16'd0, st});
    chk({name, "_valid"}, {31'd0, m_valid}, {31'd0, v});
    chk({name, "_data"}, {16'd0, m_data}, {16'd0, d});
  endtask

  // Fill an empty FIFO with DEPTH words base+i, peripheral stalled
  task automatic fill(input logic [15:0] base);
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_strobe = 1'b1;
      wr_data   = base + 16'(i);
      step();
    end
    idle_inputs();
  endtask

  // Reference model state
  logic [15:0] q[$];
  logic        m_ovf;

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    #1;
    chk_outs("reset_async", 16'h4000, 1'b0, 16'h0000);
    do_reset();
    chk_outs("reset_idle", 16'h4000, 1'b0, 16'h0000);

    // ---------------- table-driven: push 3 then drain ----------------
    vecs[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h4000, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b1, 16'h0001};
    vecs[2] = '{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h0001};
    vecs[3] = '{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0003, 1'b1, 16'h0001};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b1, 16'h0001};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0002};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1, 16'h0003};
    vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h4000, 1'b0, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      wr_strobe = vecs[i].wr;
      wr_data   = vecs[i].wr ? vecs[i].wd : 16'hxxxx;
      rd_strobe = vecs[i].rd;
      m_ready   = vecs[i].rdy;
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_status, vecs[i].exp_valid, vecs[i].exp_data);
    end
    idle_inputs();

    // ---------------- 9 pushes into depth 8 ----------------
    fill(16'h0100);
    chk_outs("full8", 16'h8008, 1'b1, 16'h0100);
    wr_strobe = 1'b1;
    wr_data   = 16'hDEAD;
    step();
    idle_inputs();
    chk_outs("drop9", 16'hA008, 1'b1, 16'h0100);
    rd_strobe = 1'b1;
    step();
    idle_inputs();
    chk_outs("ovf_clear", 16'h8008, 1'b1, 16'h0100);

    // ---------------- full + write + pop same cycle ----------------
    wr_strobe = 1'b1;
    wr_data   = 16'hBEEF;
    m_ready   = 1'b1;
    step();
    idle_inputs();
    chk_outs("full_push_pop", 16'h8008, 1'b1, 16'h0101);
    m_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      chk({"drain_order"}, {16'd0, m_data}, {16'd0, 16'h0100 + 16'(i)});
      step();
    end
    chk("drain_last", {16'd0, m_data}, {16'd0, 16'hBEEF});
    step();
    idle_inputs();
    chk_outs("drained", 16'h4000, 1'b0, 16'h0000);

    // ---------------- drop coincident with rd_strobe ----------------
    fill(16'h0200);
    wr_strobe = 1'b1;
    wr_data   = 16'h1111;
    step();
    chk("drop_a", {16'd0, status}, {16'd0, 16'hA008});
    wr_data   = 16'h2222;
    rd_strobe = 1'b1;
    step();
    idle_inputs();
    chk("drop_with_rd", {16'd0, status}, {16'd0, 16'hA008});
    rd_strobe = 1'b1;
    step();
    idle_inputs();
    chk("rd_alone_clear", {16'd0, status}, {16'd0, 16'h8008});

    // ---------------- reset mid-burst ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_strobe = 1'b1;
      wr_data   = 16'h3000 + 16'(i);
      step();
    end
    chk("pre_reset_cnt", {16'd0, status}, {16'd0, 16'h0003});
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("midburst_reset", 16'h4000, 1'b0, 16'h0000);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    step();
    chk_outs("post_reset", 16'h4000, 1'b0, 16'h0000);

    // ---------------- randomized run vs queue model ----------------
    do_reset();
    q.delete();
    m_ovf = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic        w;
      logic        rdy;
      logic        rs;
      logic [15:0] d;
      logic        pop;
      logic        full;
      logic [15:0] exp_st;
      w   = ($urandom_range(0, 99) < 55);
      rdy = ($urandom_range(0, 99) < 45);
      rs  = ($urandom_range(0, 99) < 5);
      d   = 16'($urandom);
      wr_strobe = w;
      wr_data   = w ? d : 16'hxxxx;
      m_ready   = rdy;
      rd_strobe = rs;
      full = (q.size() == DEPTH);
      pop  = (q.size() > 0) && rdy;
      if (pop) void'(q.pop_front());
      if (w && (!full || pop)) q.push_back(d);
      if (w && full && !pop) m_ovf = 1'b1;
      else if (rs) m_ovf = 1'b0;
      step();
      exp_st = {q.size() == DEPTH, q.size() == 0, m_ovf, 5'd0, 8'(q.size())};
      chk("rnd_status", {16'd0, status}, {16'd0, exp_st});
      chk("rnd_valid", {31'd0, m_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
        chk("rnd_data", {16'd0, m_data}, {16'd0, q[0]});
      end else begin
        chk("rnd_data_empty", {16'd0, m_data}, 32'd0);
      end
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
